// File: rtl/ff_bank_pkg.sv
// Shared mode encoding for the ff_bank flip-flop bank.
package ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SR = 2'd0;
    localparam mode_t MODE_JK = 2'd1;
    localparam mode_t MODE_D  = 2'd2;
    localparam mode_t MODE_T  = 2'd3;

endpackage

// File: rtl/ff_bank_if.sv
// Control/data bundle between a driver (master) and the ff_bank (slave).
interface ff_bank_if
    import ff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) ();

    logic             ce;
    logic             mode_wr;
    mode_t            mode_in;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    mode_t            mode_q;
    logic [WIDTH-1:0] err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output ce, mode_wr, mode_in, s, r, err_clr,
        input  q, nq, mode_q, err, err_cnt
    );

    modport slave (
        input  ce, mode_wr, mode_in, s, r, err_clr,
        output q, nq, mode_q, err, err_cnt
    );

endinterface

// File: rtl/ff_cell.sv
// One flip-flop channel with run-time SR/JK/D/T behaviour.
// FF_BANK_SET_DOMINANT_EN: SR with s=r=1 sets q instead of holding it.
module ff_cell
    import ff_bank_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_ce,
    input  mode_t i_mode,
    input  logic  i_s,
    input  logic  i_r,
    output logic  o_q,
    output logic  o_nq,
    output logic  o_illegal
);

    logic r_q;
    logic r_nq;
    logic w_q_next;

    always_comb begin
        w_q_next = r_q;
        case (i_mode)
            MODE_SR: begin
                unique case ({i_s, i_r})
                    2'b01:   w_q_next = 1'b0;
                    2'b10:   w_q_next = 1'b1;
`ifdef FF_BANK_SET_DOMINANT_EN
                    2'b11:   w_q_next = 1'b1;
`else
                    2'b11:   w_q_next = r_q;
`endif
                    default: w_q_next = r_q;
                endcase
            end
            MODE_JK: begin
                unique case ({i_s, i_r})
                    2'b01:   w_q_next = 1'b0;
                    2'b10:   w_q_next = 1'b1;
                    2'b11:   w_q_next = ~r_q;
                    default: w_q_next = r_q;
                endcase
            end
            MODE_D:  w_q_next = i_s;
            MODE_T:  w_q_next = r_q ^ i_s;
            default: w_q_next = r_q;
        endcase
    end

    // nq is its own register so both outputs come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q  <= 1'b0;
            r_nq <= 1'b1;
        end else if (i_ce) begin
            r_q  <= w_q_next;
            r_nq <= ~w_q_next;
        end
    end

    assign o_q       = r_q;
    assign o_nq      = r_nq;
    assign o_illegal = i_ce & (i_mode == MODE_SR) & i_s & i_r;

endmodule

// File: rtl/ff_bank.sv
// WIDTH-channel flip-flop bank with shared mode, sticky illegal flags and saturating counter.
// FF_BANK_SET_DOMINANT_EN selects set-dominant SR behaviour in every ff_cell.
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input logic       i_clk,
    input logic       i_rst,
    ff_bank_if.slave  bus
);

    localparam int unsigned PopW = $clog2(WIDTH + 1);
    localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    mode_t            r_mode;
    logic [WIDTH-1:0] r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_nq;
    logic [WIDTH-1:0] w_ill;
    logic [PopW-1:0]  w_pop;
    logic [WIDTH-1:0] w_err_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [SumW-1:0]  w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_ce      (bus.ce),
            .i_mode    (r_mode),
            .i_s       (bus.s[i]),
            .i_r       (bus.r[i]),
            .o_q       (w_q[i]),
            .o_nq      (w_nq[i]),
            .o_illegal (w_ill[i])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_ill[i]) w_pop = w_pop + PopW'(1);
        end
    end

    // Clear applies before this cycle's illegal events are added.
    always_comb begin
        w_err_base = bus.err_clr ? '0 : r_err;
        w_cnt_base = bus.err_clr ? '0 : r_err_cnt;
        w_sum      = SumW'(w_cnt_base) + SumW'(w_pop);
        w_cnt_next = (w_sum > SumW'(CntMax)) ? CntMax : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode    <= MODE_SR;
            r_err     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (bus.mode_wr) r_mode <= bus.mode_in;
            r_err     <= w_err_base | w_ill;
            r_err_cnt <= w_cnt_next;
        end
    end

    assign bus.q       = w_q;
    assign bus.nq      = w_nq;
    assign bus.mode_q  = r_mode;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;

endmodule

// File: doc/ff_bank.md
Name: ff_bank

Overview:
- Parametrised bank of WIDTH clocked flip-flop channels sharing one run-time mode: SR, JK, D or T.
- Successor to the single-channel enable-triggered RS element: proper clock, clock enable, synchronous reset and illegal-input (S=R=1) detection.
- Records illegal events in per-channel sticky flags and a saturating event counter.
- Used as the generic state-element bank in the lab datapath.

Parameters:
WIDTH, 4, number of independent flip-flop channels
CNT_W, 4, width of saturating illegal-event counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
ce  in  1  clock enable for channel state updates and illegal-event recording
mode_wr  in  1  load mode_in into mode register this cycle
mode_in  in  2  requested mode (SR=0, JK=1, D=2, T=3)
s  in  WIDTH  per-channel S / J / D / T input (by mode)
r  in  WIDTH  per-channel R / K input (ignored in D and T modes)
err_clr  in  1  clear sticky err and err_cnt
q  out  WIDTH  channel state
nq  out  WIDTH  complement of q, registered, always equal to ~q
mode_q  out  2  current mode register
err  out  WIDTH  sticky per-channel illegal-input flag
err_cnt  out  CNT_W  saturating count of illegal channel-events

Behaviour:
- Reset (rst=1 at clk edge, overrides all other inputs):
  - q=0, nq=all ones, mode_q=SR (0), err=0, err_cnt=0.
- Mode register:
  - mode_wr=1 loads mode_in at the edge, independent of ce.
  - The cycle with mode_wr=1 evaluates channels with the old mode_q; the new mode applies from the next cycle.
- Channel update when ce=1, per channel i:
  - SR: s=0,r=0 hold; s=0,r=1 q=0; s=1,r=0 q=1; s=1,r=1 illegal, behaviour per the optional feature.
  - JK: 00 hold; 01 q=0; 10 q=1; 11 toggle. Never illegal.
  - D: q=s; r ignored.
  - T: s=1 toggle, s=0 hold; r ignored.
- ce=0: q/nq hold, no illegal events recorded; mode_wr and err_clr still act.
- nq is updated in the same edge as q; q & nq == 0 and q | nq == all ones at every edge after reset.
- Latency: one cycle from inputs to q/nq/err/err_cnt.
- Illegal event: ce=1, mode_q=SR, s[i]=r[i]=1.
  - Sets err[i] (sticky).
  - err_cnt += number of illegal channels that cycle (popcount), saturating at 2^CNT_W-1; no wrap.
- err_clr:
  - Alone: err=0, err_cnt=0 next cycle.
  - Same cycle as illegal events: the clear applies first, then that cycle's events. err=that cycle's illegal mask; err_cnt=that cycle's popcount, saturated.

Optional Feature:
- Macro: FF_BANK_SET_DOMINANT_EN
- Defined: SR s=r=1 forces q=1 (set-dominant). Still counts as an illegal event (err/err_cnt updated).
- Undefined: SR s=r=1 holds q, and records the illegal event.

Decomposition:
- Package ff_bank_pkg:
  - mode constants MODE_SR=2'd0, MODE_JK=2'd1, MODE_D=2'd2, MODE_T=2'd3.
  - 2-bit mode typedef.
- Sub-module ff_cell (one channel):
  - Inputs: clk, rst, ce, mode, s, r.
  - Outputs: q, nq, illegal (combinational).
  - Instanced WIDTH times by generate.
- Top level holds the mode register, err, the popcount and the saturating counter.

Test Plan (WIDTH=4, CNT_W=4):
- Reset/SR: rst=1 -> q=0000, nq=1111, mode_q=0, err=0, err_cnt=0. Then ce=1, s=0101, r=1010 -> q=0101, nq=1010. Then s=0000, r=0000 -> holds 0101.
- Illegal SR: q=0101, s=1111, r=0011 -> err=0011, err_cnt=2, q=1101 without macro; q=1111 with FF_BANK_SET_DOMINANT_EN. Repeat 7 more cycles -> err_cnt saturates at 15.
- err_clr with simultaneous illegal: err=0011, err_cnt=15; err_clr=1, s=r=1000 -> err=1000, err_cnt=1.
- Mode switch timing: mode_wr=1, mode_in=T, s=1111, r=0000, ce=1 from q=0000 -> SR applied that cycle: q=1111, mode_q=3. Next cycle s=0110 -> q=1001.
- JK/D: mode JK, q=1001, s=1100, r=1010 -> q=0101. Mode D, s=0011, r=1111 -> q=0011, err unchanged.
- ce gating and sync reset: ce=0, s=r=1111 in SR -> q, err, err_cnt unchanged. rst=1 together with mode_wr=1, mode_in=D -> q=0, nq=1111, mode_q=0 (reset wins); rst has no effect until the clock edge.
